tile_flusher: RTL and testbench
===============================

TILE_FLUSHER -- requirements
Module: tile_flusher

Interface
REQ-001 SHALL have parameter nanoTileDim, default 8, tile edge in pixels.
REQ-002 SHALL have parameter screenWidth, default 640, framebuffer row pitch and horizontal clip limit.
REQ-003 SHALL have parameter screenHeight, default 480, vertical clip limit.
REQ-004 SHALL have port BOARD_CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port startFlush  input  1  level request to flush one tile.
REQ-007 SHALL have port flushTileID  input  1  selects the source tile: 0 = nanoTile0, 1 = nanoTile1.
REQ-008 SHALL have port nanoTile0  input  16 x [nanoTileDim][nanoTileDim]  RGB565 tile buffer 0, indexed [col][row].
REQ-009 SHALL have port nanoTile1  input  16 x [nanoTileDim][nanoTileDim]  RGB565 tile buffer 1, indexed [col][row].
REQ-010 SHALL have port tileOffsetX, tileOffsetY  input  10 each  screen position of tile pixel [0][0].
REQ-011 SHALL have port sramAddr  output  20  framebuffer word address.
REQ-012 SHALL have port sramData  output  16  pixel write data.
REQ-013 SHALL have port sramReq  output  1  write request.
REQ-014 SHALL have port sramAck  input  1  write accepted.
REQ-015 SHALL have port doneFlushing  output  1  tile fully written.

Function
REQ-016 SHALL implement states IDLE, LATCH, ISSUE, WAIT, NEXT, DONE; outputs registered or Moore-decoded from registered state.
REQ-017 SHALL, in IDLE with startFlush=1, move to LATCH; otherwise remain in IDLE.
REQ-018 SHALL, on the LATCH edge, capture flushTileID, tileOffsetX and tileOffsetY, and clear col and row to 0; later changes to these inputs are ignored until the next LATCH.
REQ-019 SHALL form pixel coordinates x = latchedX + col and y = latchedY + row at 11-bit width with no truncation.
REQ-020 SHALL, in ISSUE with x < screenWidth and y < screenHeight, register sramAddr = y*screenWidth + x, register sramData = selected tile[col][row], and move to WAIT.
REQ-021 SHALL, in ISSUE with a clipped pixel (x >= screenWidth or y >= screenHeight), move directly to NEXT without asserting sramReq.
REQ-022 SHALL hold sramReq=1 throughout WAIT, with sramAddr and sramData stable.
REQ-023 SHALL leave WAIT for NEXT on the first edge at which sramAck=1; sramReq SHALL be 0 from that edge on.
REQ-024 SHALL ignore sramAck outside WAIT.
REQ-025 SHALL, in NEXT, increment col; when col = nanoTileDim-1, wrap col to 0 and increment row.
REQ-026 SHALL, in NEXT at col = row = nanoTileDim-1, move to DONE; otherwise return to ISSUE.
REQ-027 SHALL visit pixels in raster order: col fastest, then row.
REQ-028 SHALL hold doneFlushing=1 exactly while in DONE.
REQ-029 SHALL remain in DONE while startFlush=1 and return to IDLE on the first edge with startFlush=0.
REQ-030 SHALL ignore startFlush in every state other than IDLE and DONE.
REQ-031 SHALL take 3 cycles per written pixel when sramAck=1 immediately, plus 1 cycle per extra WAIT cycle, and 2 cycles per clipped pixel.
REQ-032 SHALL, with nanoTileDim = 8, sramAck tied high and no clipping, enter DONE on edge E+193, where E is the edge sampling startFlush in IDLE.

Reset
REQ-033 SHALL, while RESET=1 and independent of the clock, force state IDLE, sramReq=0, doneFlushing=0, sramAddr=0, sramData=0, col=0 and row=0.
REQ-034 SHALL, on reset asserted mid-flush (including during WAIT), drop sramReq immediately and not resume the flush; a new startFlush is required after RESET deasserts.

Verification
REQ-035 SHALL cover: tileOffset (0,0), ID 0, tile[c][r] = {r,c} pattern, sramAck tied 1 -> 64 writes at addresses r*640 + c with matching data; doneFlushing high at E+193.
REQ-036 SHALL cover: ID 1, offset (16,8), nanoTile0 all 0xFFFF, nanoTile1 all 0x07E0 -> all 64 writes carry 0x07E0; first address 5136, last address 9623.
REQ-037 SHALL cover: offset (636,476) -> exactly 16 writes (col 0..3, row 0..3); first address 305276; no sramReq for clipped pixels.
REQ-038 SHALL cover: sramAck delayed 3 cycles on pixel 5 -> sramAddr, sramData and sramReq held stable for the 4 WAIT cycles; no pixel skipped or duplicated.
REQ-039 SHALL cover: RESET pulsed in WAIT of pixel 20 -> sramReq=0 within the same cycle, state IDLE, doneFlushing=0; a subsequent startFlush restarts at address tileOffsetY*640 + tileOffsetX.
REQ-040 SHALL cover: startFlush held high through DONE -> no second flush; dropping startFlush -> IDLE and doneFlushing=0 on the next edge.

Source files
------------

// File: rtl/tile_flusher_if.sv
// Framebuffer SRAM write port: word address, pixel data and a req/ack handshake.
// The flusher holds req with stable address/data until the SRAM side acks.
interface tile_flusher_if;
  logic [19:0] sramAddr;
  logic [15:0] sramData;
  logic        sramReq;
  logic        sramAck;

  modport master (
    output sramAddr,
    output sramData,
    output sramReq,
    input  sramAck
  );

  modport slave (
    input  sramAddr,
    input  sramData,
    input  sramReq,
    output sramAck
  );
endinterface

// File: rtl/tile_flusher.sv
// Copies one nanoTileDim x nanoTileDim RGB565 tile into the framebuffer in raster
// order, clipping pixels that fall outside the screen.
module tile_flusher #(
  parameter int nanoTileDim  = 8,
  parameter int screenWidth  = 640,
  parameter int screenHeight = 480
) (
  input  logic        BOARD_CLK,
  input  logic        RESET,
  input  logic        startFlush,
  input  logic        flushTileID,
  input  logic [15:0] nanoTile0 [nanoTileDim][nanoTileDim],
  input  logic [15:0] nanoTile1 [nanoTileDim][nanoTileDim],
  input  logic [9:0]  tileOffsetX,
  input  logic [9:0]  tileOffsetY,
  tile_flusher_if.master sram,
  output logic        doneFlushing
);

  localparam int idx_w = (nanoTileDim > 1) ? $clog2(nanoTileDim) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(nanoTileDim - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ISSUE,
    WAIT,
    NEXT,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic             tile_sel;
  logic [9:0]       base_x;
  logic [9:0]       base_y;
  logic [idx_w-1:0] col;
  logic [idx_w-1:0] row;
  logic [19:0]      addr_q;
  logic [15:0]      data_q;

  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        in_bounds;
  logic        last_pixel;
  logic [19:0] pix_addr;
  logic [15:0] pix_data;

  // Coordinates are 11 bits wide so offset + col never wraps before the clip test.
  assign pix_x      = {1'b0, base_x} + 11'(col);
  assign pix_y      = {1'b0, base_y} + 11'(row);
  assign in_bounds  = (pix_x < 11'(screenWidth)) && (pix_y < 11'(screenHeight));
  assign last_pixel = (col == last_idx) && (row == last_idx);
  assign pix_addr   = 20'(pix_y) * 20'(screenWidth) + 20'(pix_x);
  assign pix_data   = tile_sel ? nanoTile1[col][row] : nanoTile0[col][row];

  always_ff @(posedge BOARD_CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (startFlush) state_next = LATCH;
      LATCH:   state_next = ISSUE;
      ISSUE:   state_next = in_bounds ? WAIT : NEXT;
      WAIT:    if (sram.sramAck) state_next = NEXT;
      NEXT:    state_next = last_pixel ? DONE : ISSUE;
      DONE:    if (!startFlush) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Tile selection and offsets are frozen at LATCH; address/data only load for visible pixels.
  always_ff @(posedge BOARD_CLK or posedge RESET) begin
    if (RESET) begin
      tile_sel <= 1'b0;
      base_x   <= '0;
      base_y   <= '0;
      col      <= '0;
      row      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      case (state)
        LATCH: begin
          tile_sel <= flushTileID;
          base_x   <= tileOffsetX;
          base_y   <= tileOffsetY;
          col      <= '0;
          row      <= '0;
        end
        ISSUE: begin
          if (in_bounds) begin
            addr_q <= pix_addr;
            data_q <= pix_data;
          end
        end
        NEXT: begin
          if (col == last_idx) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sram.sramAddr = addr_q;
  assign sram.sramData = data_q;
  assign sram.sramReq  = (state == WAIT);
  assign doneFlushing  = (state == DONE);

endmodule

// File: tb/tb_tile_flusher.sv
// Directed bench for tile_flusher: raster order, clipping, ack stalls, reset abort
// and startFlush hold-through-DONE behaviour against hand-computed values.
module tb_tile_flusher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_flush = 1'b0;
  logic        tile_id = 1'b0;
  logic [15:0] tile0 [8][8];
  logic [15:0] tile1 [8][8];
  logic [9:0]  off_x = '0;
  logic [9:0]  off_y = '0;
  logic        done;

  int pass_count = 0;
  int check_count = 0;
  int req_cycles = 0;

  logic [19:0] wr_addr [$];
  logic [15:0] wr_data [$];

  tile_flusher_if sram_bus ();

  tile_flusher #(
    .nanoTileDim (8),
    .screenWidth (640),
    .screenHeight(480)
  ) dut (
    .BOARD_CLK   (clk),
    .RESET       (rst),
    .startFlush  (start_flush),
    .flushTileID (tile_id),
    .nanoTile0   (tile0),
    .nanoTile1   (tile1),
    .tileOffsetX (off_x),
    .tileOffsetY (off_y),
    .sram        (sram_bus),
    .doneFlushing(done)
  );

  always #5 clk = ~clk;

  // A write is accepted on any rising edge that sees req and ack together.
  always @(posedge clk) begin
    if (sram_bus.sramReq) begin
      req_cycles++;
      if (sram_bus.sramAck) begin
        wr_addr.push_back(sram_bus.sramAddr);
        wr_data.push_back(sram_bus.sramData);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    assert (got === exp) pass_count++;
    else $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic fill_pattern();
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) begin
        tile0[c][r] = 16'((r << 8) | c);
        tile1[c][r] = ~16'((r << 8) | c);
      end
  endtask

  task automatic fill_solid(input logic [15:0] v0, input logic [15:0] v1);
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) begin
        tile0[c][r] = v0;
        tile1[c][r] = v1;
      end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start_flush = 1'b1;
    @(negedge clk) start_flush = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  // Compares a full 64-write log against the {row,col} pattern of tile0 at (bx,by).
  task automatic raster_errors(input int bx, input int by, output int errs);
    errs = 0;
    if (wr_addr.size() != 64) begin
      errs = 64;
    end else begin
      for (int i = 0; i < 64; i++) begin
        if (wr_addr[i] !== 20'((by + i / 8) * 640 + bx + i % 8)) errs++;
        if (wr_data[i] !== 16'(((i / 8) << 8) | (i % 8))) errs++;
      end
    end
  endtask

  initial begin
    int errs;
    int acked;
    int hold;
    int n;
    int req_base;
    logic [19:0] h_addr;
    logic [15:0] h_data;

    sram_bus.sramAck = 1'b0;
    fill_pattern();

    #2;
    check("rst_req", 32'(sram_bus.sramReq), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(sram_bus.sramAddr), 32'd0);
    check("rst_data", 32'(sram_bus.sramData), 32'd0);
    @(negedge clk) rst = 1'b0;
    sram_bus.sramAck = 1'b1;

    // Offset (0,0), tile 0, ack tied high: DONE exactly 193 edges after E.
    $display("[TB] flush at origin, ack tied high");
    clear_log();
    @(negedge clk) start_flush = 1'b1;
    @(posedge clk);
    repeat (192) @(posedge clk);
    #1 check("a_done_e192", 32'(done), 32'd0);
    @(posedge clk);
    #1 check("a_done_e193", 32'(done), 32'd1);
    repeat (5) @(negedge clk);
    check("a_done_held", 32'(done), 32'd1);
    check("a_write_count", 32'(wr_addr.size()), 32'd64);
    raster_errors(0, 0, errs);
    check("a_raster_errs", 32'(errs), 32'd0);
    check("a_last_addr", 32'(wr_addr[$]), 32'd4487);
    start_flush = 1'b0;
    @(posedge clk);
    #1 check("a_done_dropped", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("a_no_second_flush", 32'(wr_addr.size()), 32'd64);

    // Tile 1 at (16,8); inputs changed after LATCH must not matter.
    $display("[TB] tile 1 at (16,8)");
    fill_solid(16'hFFFF, 16'h07E0);
    tile_id = 1'b1;
    off_x = 10'd16;
    off_y = 10'd8;
    clear_log();
    @(negedge clk) start_flush = 1'b1;
    repeat (3) @(negedge clk);
    tile_id = 1'b0;
    off_x = 10'd0;
    off_y = 10'd0;
    wait_done("b_done", 400);
    start_flush = 1'b0;
    check("b_write_count", 32'(wr_addr.size()), 32'd64);
    check("b_first_addr", 32'(wr_addr[0]), 32'd5136);
    check("b_last_addr", 32'(wr_addr[$]), 32'd9623);
    errs = 0;
    foreach (wr_data[i]) if (wr_data[i] !== 16'h07E0) errs++;
    check("b_data_errs", 32'(errs), 32'd0);
    @(negedge clk);

    // Corner tile at (636,476): only a 4x4 block is on screen.
    $display("[TB] clipped corner tile");
    fill_pattern();
    off_x = 10'd636;
    off_y = 10'd476;
    clear_log();
    req_base = req_cycles;
    pulse_start();
    wait_done("c_done", 400);
    check("c_write_count", 32'(wr_addr.size()), 32'd16);
    check("c_first_addr", 32'(wr_addr[0]), 32'd305276);
    check("c_last_addr", 32'(wr_addr[$]), 32'd307199);
    check("c_first_data", 32'(wr_data[0]), 32'h0000);
    check("c_last_data", 32'(wr_data[$]), 32'h0303);
    check("c_req_cycles", 32'(req_cycles - req_base), 32'd16);
    @(negedge clk);

    // Ack withheld for 3 extra cycles on pixel 5; bus must hold still.
    $display("[TB] ack stall on pixel 5");
    off_x = 10'd0;
    off_y = 10'd0;
    clear_log();
    req_base = req_cycles;
    sram_bus.sramAck = 1'b0;
    pulse_start();
    acked = 0;
    hold = 0;
    errs = 0;
    n = 0;
    h_addr = '0;
    h_data = '0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
      if (sram_bus.sramReq) begin
        if (acked == 5 && hold < 3) begin
          if (hold == 0) begin
            h_addr = sram_bus.sramAddr;
            h_data = sram_bus.sramData;
          end else if (sram_bus.sramAddr !== h_addr || sram_bus.sramData !== h_data) begin
            errs++;
          end
          sram_bus.sramAck = 1'b0;
          hold++;
        end else begin
          if (acked == 5 && (sram_bus.sramAddr !== h_addr || sram_bus.sramData !== h_data))
            errs++;
          sram_bus.sramAck = 1'b1;
          acked++;
        end
      end else begin
        sram_bus.sramAck = 1'b1;
      end
    end
    check("d_done", 32'(done), 32'd1);
    check("d_hold_cycles", 32'(hold), 32'd3);
    check("d_hold_addr", 32'(h_addr), 32'd5);
    check("d_hold_data", 32'(h_data), 32'h0005);
    check("d_stable_errs", 32'(errs), 32'd0);
    check("d_req_cycles", 32'(req_cycles - req_base), 32'd67);
    raster_errors(0, 0, errs);
    check("d_raster_errs", 32'(errs), 32'd0);
    sram_bus.sramAck = 1'b1;
    @(negedge clk);

    // Reset during WAIT of pixel 20 aborts; a fresh start begins at the tile origin.
    $display("[TB] reset during pixel 20 wait");
    off_x = 10'd100;
    off_y = 10'd50;
    clear_log();
    pulse_start();
    acked = 0;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (sram_bus.sramReq) begin
        if (acked == 20) break;
        acked++;
      end
    end
    check("e_reached_px20", 32'(acked), 32'd20);
    rst = 1'b1;
    #1;
    check("e_rst_req", 32'(sram_bus.sramReq), 32'd0);
    check("e_rst_done", 32'(done), 32'd0);
    check("e_rst_addr", 32'(sram_bus.sramAddr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("e_writes_before_abort", 32'(wr_addr.size()), 32'd20);
    check("e_no_resume", 32'(sram_bus.sramReq), 32'd0);
    clear_log();
    pulse_start();
    wait_done("e_done", 400);
    check("e_write_count", 32'(wr_addr.size()), 32'd64);
    check("e_first_addr", 32'(wr_addr[0]), 32'd32100);
    raster_errors(100, 50, errs);
    check("e_raster_errs", 32'(errs), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
